// File: rtl/frame_capture_ctrl.sv
// Single-frame capture sequencer: gates one camera frame into SDRAM, then streams it out as Avalon-ST RGB.
// Optional watchdog on ARM/CAPTURE is enabled by defining FRAME_TIMEOUT_EN.
module frame_capture_ctrl #(
   parameter int ASIZE          = 23,
   parameter int H_ACTIVE       = 640,
   parameter int V_ACTIVE       = 480,
   parameter int FRAME_BASE     = 0,
   parameter int BURST_LEN      = 256,
   parameter int TIMEOUT_CYCLES = 5000000
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic             capture_req,
   input  logic             frame_sof,
   input  logic             wr_pixel_valid,
   output logic             wr_en,
   output logic             img_captured,
   output logic             rd_req,
   output logic [ASIZE-1:0] rd_start_addr,
   output logic [ASIZE-1:0] rd_max_addr,
   output logic [10:0]      rd_len,
   input  logic [9:0]       rd_pixel_data,
   input  logic             rd_fifo_empty,
   output logic             rd_fifo_rdreq,
   output logic [23:0]      st_data,
   output logic             st_valid,
   output logic             st_sop,
   output logic             st_eop,
   input  logic             st_ready,
   output logic             cap_err
);

   localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;
   localparam int PIX_W        = $clog2(FRAME_PIXELS);
   localparam int CNT_W        = $clog2(FRAME_PIXELS + 1);

   typedef enum logic [2:0] {IDLE, ARM, CAPTURE, READ_REQ, STREAM} state_t;

   state_t           state, state_next;
   logic [PIX_W-1:0] pix_cnt;
   logic [CNT_W-1:0] popped;
   logic [CNT_W-1:0] beat_cnt;
   logic             last_accept;
   logic             abort;
   logic             timeout;
   logic             beat_done;

   assign beat_done = st_valid && st_ready;

   always_ff @(posedge CLOCK_50) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // NOTE: every output of this block gets a default first, so no path can leave a latch behind.
   always_comb begin
      state_next    = state;
      wr_en         = 1'b0;
      rd_req        = 1'b0;
      rd_fifo_rdreq = 1'b0;
      last_accept   = 1'b0;
      abort         = 1'b0;
      case (state)
         IDLE: if (capture_req) state_next = ARM;
         ARM: begin
            if (frame_sof) begin
               state_next = CAPTURE;
            end else if (timeout) begin
               abort      = 1'b1;
               state_next = IDLE;
            end
         end
         CAPTURE: begin
            wr_en = 1'b1;
            if (wr_pixel_valid && pix_cnt == PIX_W'(FRAME_PIXELS - 1)) begin
               last_accept = 1'b1;
               state_next  = READ_REQ;
            end else if (timeout) begin
               abort      = 1'b1;
               state_next = IDLE;
            end
         end
         READ_REQ: begin
            rd_req     = 1'b1;
            state_next = STREAM;
         end
         STREAM: begin
            rd_fifo_rdreq = !rd_fifo_empty && (!st_valid || st_ready)
                            && (popped < CNT_W'(FRAME_PIXELS));
            if (beat_done && beat_cnt == CNT_W'(FRAME_PIXELS - 1)) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         pix_cnt       <= '0;
         img_captured  <= 1'b0;
         rd_start_addr <= '0;
         rd_max_addr   <= '0;
         rd_len        <= '0;
         cap_err       <= 1'b0;
      end else begin
         cap_err <= abort;
         if (state == IDLE && capture_req) img_captured <= 1'b0;
         if (state == ARM && frame_sof) pix_cnt <= '0;
         if (state == CAPTURE) begin
            if (last_accept) begin
               img_captured  <= 1'b1;
               rd_start_addr <= ASIZE'(FRAME_BASE);
               rd_max_addr   <= ASIZE'(FRAME_BASE + FRAME_PIXELS);
               rd_len        <= 11'(BURST_LEN);
            end else if (frame_sof) begin
               // Short frame: restart, and a coincident pixel becomes pixel 0.
               pix_cnt <= wr_pixel_valid ? PIX_W'(1) : '0;
            end else if (wr_pixel_valid) begin
               pix_cnt <= pix_cnt + PIX_W'(1);
            end
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         popped   <= '0;
         beat_cnt <= '0;
         st_data  <= '0;
         st_valid <= 1'b0;
         st_sop   <= 1'b0;
         st_eop   <= 1'b0;
      end else begin
         if (state == READ_REQ) begin
            popped   <= '0;
            beat_cnt <= '0;
         end
         if (rd_fifo_rdreq) begin
            st_valid <= 1'b1;
            st_data  <= {3{rd_pixel_data[9:2]}};
            st_sop   <= (popped == '0);
            st_eop   <= (popped == CNT_W'(FRAME_PIXELS - 1));
            popped   <= popped + CNT_W'(1);
         end else if (beat_done) begin
            st_valid <= 1'b0;
            st_sop   <= 1'b0;
            st_eop   <= 1'b0;
         end
         if (beat_done) beat_cnt <= beat_cnt + CNT_W'(1);
      end
   end

`ifdef FRAME_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_cnt;

   always_ff @(posedge CLOCK_50) begin
      if (reset)                                wd_cnt <= '0;
      else if (state_next != state)             wd_cnt <= '0;
      else if (state == ARM || state == CAPTURE) wd_cnt <= wd_cnt + WD_W'(1);
   end

   assign timeout = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout;
   assign timeout        = 1'b0;
   assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

   // Only the top 8 bits of the 10-bit pixel reach the grey output.
   logic unused_pixel_lsbs;
   assign unused_pixel_lsbs = ^rd_pixel_data[1:0];

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Randomised bench for frame_capture_ctrl against a queue-based frame/FIFO reference model.
// Watchdog checks follow FRAME_TIMEOUT_EN when the bench is built with it defined.
module tb_frame_capture_ctrl;

   localparam int ASIZE = 23;
   localparam int H     = 8;
   localparam int V     = 4;
   localparam int FP    = H * V;
   localparam int BURST = 16;
   localparam int TMO   = 100;

   logic             clk = 1'b0;
   logic             reset, capture_req, frame_sof, wr_pixel_valid;
   logic             wr_en, img_captured, rd_req;
   logic [ASIZE-1:0] rd_start_addr, rd_max_addr;
   logic [10:0]      rd_len;
   logic [9:0]       rd_pixel_data;
   logic             rd_fifo_empty, rd_fifo_rdreq;
   logic [23:0]      st_data;
   logic             st_valid, st_sop, st_eop, st_ready, cap_err;

   int checks = 0;
   int errors = 0;
   logic [9:0] fifo_q[$];

   always #5 clk = ~clk;

   frame_capture_ctrl #(
      .ASIZE(ASIZE), .H_ACTIVE(H), .V_ACTIVE(V), .FRAME_BASE(0),
      .BURST_LEN(BURST), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .CLOCK_50(clk), .reset(reset), .capture_req(capture_req), .frame_sof(frame_sof),
      .wr_pixel_valid(wr_pixel_valid), .wr_en(wr_en), .img_captured(img_captured),
      .rd_req(rd_req), .rd_start_addr(rd_start_addr), .rd_max_addr(rd_max_addr),
      .rd_len(rd_len), .rd_pixel_data(rd_pixel_data), .rd_fifo_empty(rd_fifo_empty),
      .rd_fifo_rdreq(rd_fifo_rdreq), .st_data(st_data), .st_valid(st_valid),
      .st_sop(st_sop), .st_eop(st_eop), .st_ready(st_ready), .cap_err(cap_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_fifo();
      rd_fifo_empty = (fifo_q.size() == 0);
      rd_pixel_data = rd_fifo_empty ? 10'($urandom) : fifo_q[0];
   endtask

   task automatic check_zero(input string ctx);
      check({ctx, "_wr_en"},    wr_en, 0);
      check({ctx, "_img"},      img_captured, 0);
      check({ctx, "_rd_req"},   rd_req, 0);
      check({ctx, "_start"},    rd_start_addr, 0);
      check({ctx, "_max"},      rd_max_addr, 0);
      check({ctx, "_len"},      rd_len, 0);
      check({ctx, "_rdreq"},    rd_fifo_rdreq, 0);
      check({ctx, "_st_data"},  st_data, 0);
      check({ctx, "_st_valid"}, st_valid, 0);
      check({ctx, "_st_sop"},   st_sop, 0);
      check({ctx, "_st_eop"},   st_eop, 0);
      check({ctx, "_cap_err"},  cap_err, 0);
   endtask

   // Request, wait arm_wait cycles, start the frame, then count accepts until a full frame.
   task automatic run_capture(input int arm_wait, input int short_at);
      int acc = 0;
      int cyc = 0;
      bit restarted = 0;
      bit v;
      capture_req = 1; frame_sof = 0; wr_pixel_valid = 0;
      @(negedge clk);
      check("req_wr_en", wr_en, 0);
      step();
      capture_req = 0;
      for (int i = 0; i < arm_wait; i++) begin
         wr_pixel_valid = 1'($urandom);
         @(negedge clk);
         check("arm_wr_en", wr_en, 0);
         check("arm_img", img_captured, 0);
         check("arm_cap_err", cap_err, 0);
         step();
      end
      frame_sof = 1; wr_pixel_valid = 1'($urandom);
      @(negedge clk);
      check("sof_wr_en", wr_en, 0);
      check("sof_img", img_captured, 0);
      step();
      frame_sof = 0;
      while (acc < FP && cyc < 1000) begin
         v = ($urandom_range(0, 7) != 0);
         wr_pixel_valid = v;
         capture_req = ($urandom_range(0, 15) == 0);
         frame_sof = (short_at >= 0 && !restarted && acc == short_at);
         if (frame_sof) restarted = 1;
         @(negedge clk);
         check("cap_wr_en", wr_en, 1);
         check("cap_rd_req", rd_req, 0);
         check("cap_img", img_captured, 0);
         acc = frame_sof ? int'(v) : acc + int'(v);
         cyc++;
         step();
      end
      frame_sof = 0; wr_pixel_valid = 0; capture_req = 0;
      if (cyc >= 1000) check("cap_bound", 0, 1);
      @(negedge clk);
      check("rr_rd_req", rd_req, 1);
      check("rr_wr_en", wr_en, 0);
      check("rr_img", img_captured, 1);
      check("rr_start", rd_start_addr, 0);
      check("rr_max", rd_max_addr, FP);
      check("rr_len", rd_len, BURST);
      step();
   endtask

   // Stream the frame out; preload fills the FIFO up front, otherwise it trickles in with gaps.
   task automatic run_stream(input bit preload, input int abort_at);
      logic [9:0]  pix [FP+1];
      logic [23:0] held_data = '0;
      logic        held_sop = 0, held_eop = 0;
      logic [9:0]  p;
      int beat = 0, popped = 0, pushed = 0, cyc = 0;
      bit stalled = 0, pop = 0, popped_last = 0;
      for (int i = 0; i <= FP; i++) pix[i] = 10'($urandom);
      fifo_q.delete();
      if (preload) begin
         for (int i = 0; i <= FP; i++) fifo_q.push_back(pix[i]);
         pushed = FP + 1;
      end
      drive_fifo();
      while (beat < FP && cyc < 2000) begin
         if (abort_at >= 0 && beat == abort_at) break;
         st_ready = 1'($urandom);
         capture_req = ($urandom_range(0, 15) == 0);
         @(negedge clk);
         check("st_rd_req", rd_req, 0);
         check("st_img", img_captured, 1);
         check("st_wr_en", wr_en, 0);
         check("st_max", rd_max_addr, FP);
         check("st_rdreq", rd_fifo_rdreq,
               (fifo_q.size() > 0) && (!st_valid || st_ready) && (popped < FP));
         if (popped_last) check("valid_after_pop", st_valid, 1);
         if (stalled) begin
            check("stall_valid", st_valid, 1);
            check("stall_data", st_data, held_data);
            check("stall_sop", st_sop, held_sop);
            check("stall_eop", st_eop, held_eop);
         end
         if (st_valid && st_ready) begin
            p = pix[beat];
            check("beat_data", st_data, {3{p[9:2]}});
            check("beat_sop", st_sop, beat == 0);
            check("beat_eop", st_eop, beat == FP - 1);
            beat++;
         end
         stalled = st_valid && !st_ready;
         held_data = st_data; held_sop = st_sop; held_eop = st_eop;
         pop = rd_fifo_rdreq && (fifo_q.size() > 0);
         popped_last = pop;
         step();
         if (pop) begin
            void'(fifo_q.pop_front());
            popped++;
         end
         if (!preload && pushed < FP && $urandom_range(0, 1) == 1) begin
            fifo_q.push_back(pix[pushed]);
            pushed++;
         end
         drive_fifo();
         cyc++;
      end
      capture_req = 0;
      if (abort_at >= 0) begin
         st_ready = 1'($urandom);
         reset = 1;
         step();
         @(negedge clk);
         check_zero("mid_rst");
         reset = 0;
         step();
      end else begin
         if (beat < FP) check("stream_bound", beat, FP);
         st_ready = 1;
         @(negedge clk);
         check("end_valid", st_valid, 0);
         check("end_rdreq", rd_fifo_rdreq, 0);
         check("end_img", img_captured, 1);
         step();
      end
      st_ready = 0;
      fifo_q.delete();
      drive_fifo();
   endtask

   initial begin
      reset = 1; capture_req = 1; frame_sof = 0; wr_pixel_valid = 0; st_ready = 0;
      drive_fifo();
      repeat (3) step();
      capture_req = 0;
      @(negedge clk);
      check_zero("in_rst");
      reset = 0;
      step();
      @(negedge clk);
      check_zero("post_rst");
      step();
      // A request seen only during reset must not have armed the capture.
      frame_sof = 1;
      step();
      frame_sof = 0;
      for (int i = 0; i < 5; i++) begin
         wr_pixel_valid = 1;
         @(negedge clk);
         check("idle_wr_en", wr_en, 0);
         step();
      end
      wr_pixel_valid = 0;

      run_capture(2, -1);
      run_stream(1, -1);
      run_capture(0, 10);
      run_stream(0, -1);
      for (int r = 0; r < 3; r++) begin
         run_capture($urandom_range(0, 4), ($urandom_range(0, 1) == 1) ? $urandom_range(0, FP - 2) : -1);
         run_stream(1'($urandom), -1);
      end

`ifdef FRAME_TIMEOUT_EN
      begin
         int pulses = 0;
         capture_req = 1;
         step();
         capture_req = 0;
         for (int i = 0; i < TMO + 20; i++) begin
            wr_pixel_valid = 1'($urandom);
            @(negedge clk);
            check("tmo_wr_en", wr_en, 0);
            check("tmo_img", img_captured, 0);
            if (cap_err === 1'b1) pulses++;
            step();
         end
         check("tmo_pulses", pulses, 1);
         frame_sof = 1;
         step();
         frame_sof = 0;
         for (int i = 0; i < 5; i++) begin
            wr_pixel_valid = 1;
            @(negedge clk);
            check("tmo_idle_wr_en", wr_en, 0);
            step();
         end
         wr_pixel_valid = 0;
      end
`else
      run_capture(TMO + 20, -1);
      run_stream(1, -1);
`endif

      run_capture(1, -1);
      run_stream(0, 5);
      run_capture(1, -1);
      run_stream(1, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
